vend_coin_payout: RTL and testbench

//  Change/payout side of the vending machine: the coin acceptor takes coins in; this block pays coins out.

---
 rtl/vend_pkg.sv | 19 +
 rtl/vend_coin_select.sv | 19 +
 rtl/vend_coin_payout.sv | 118 +++++++++++
 tb/tb_vend_coin_payout.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared definitions for the vending machine payout path:
// payout FSM state encoding, coin values and a coin value helper.
package vend_pkg;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ISSUE  = 2'd1;
    localparam logic [1:0] SETTLE = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    localparam int VAL_W = 2;

    localparam logic [VAL_W-1:0] COIN1_VAL = 2'd1;
    localparam logic [VAL_W-1:0] COIN2_VAL = 2'd2;

    function automatic logic [VAL_W-1:0] coin_value(input logic sel);
        return sel ? COIN2_VAL : COIN1_VAL;
    endfunction

endpackage

// File: rtl/vend_coin_select.sv
// Combinational coin chooser: picks a 2-unit coin when at least 2 units
// remain and the 2-coin tube is not empty, otherwise a 1-unit coin.
// Ports: remain (credit left), coin2_empty (tube empty) ->
//        sel (1 = 2-unit coin), value (units of the chosen coin).
module vend_coin_select
    import vend_pkg::*;
#(
    parameter int CREDIT_W = 4
) (
    input  logic [CREDIT_W-1:0] remain,
    input  logic                coin2_empty,
    output logic                sel,
    output logic [VAL_W-1:0]    value
);

    assign sel   = (remain >= CREDIT_W'(2)) && !coin2_empty;
    assign value = coin_value(sel);

endmodule

// File: rtl/vend_coin_payout.sv
// Change payout controller: pays a requested amount out one coin at a time
// to the hopper over a valid/ack handshake, preferring 2-unit coins.
// Ports: clk, rstn (async active-low), req/amount (change request),
//        coin2_empty, hopper_ack (hopper side), busy, coin_vld, coin_sel,
//        done (1-cycle completion pulse), total (lifetime units paid).
// Optional feature: define PAYOUT_TOTAL_EN to add the saturating total
// register, the total port and the TOTAL_W parameter.
module vend_coin_payout
    import vend_pkg::*;
#(
    parameter int CREDIT_W = 4
`ifdef PAYOUT_TOTAL_EN
    ,
    parameter int TOTAL_W  = 8
`endif
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                req,
    input  logic [CREDIT_W-1:0] amount,
    input  logic                coin2_empty,
    input  logic                hopper_ack,
    output logic                busy,
    output logic                coin_vld,
    output logic                coin_sel,
    output logic                done
`ifdef PAYOUT_TOTAL_EN
    ,
    output logic [TOTAL_W-1:0]  total
`endif
);

    logic [1:0]          state;
    logic [CREDIT_W-1:0] remain;
    logic [VAL_W-1:0]    coin_val;

    logic [CREDIT_W-1:0] sel_src;
    logic [CREDIT_W-1:0] remain_nxt;
    logic                nxt_sel;
    logic [VAL_W-1:0]    nxt_val;

    // From IDLE the remain register is loaded on the same edge that
    // enters ISSUE, so the coin choice must look at amount directly.
    assign sel_src    = (state == IDLE) ? amount : remain;
    assign remain_nxt = remain - CREDIT_W'(coin_val);

    vend_coin_select #(
        .CREDIT_W (CREDIT_W)
    ) u_sel (
        .remain      (sel_src),
        .coin2_empty (coin2_empty),
        .sel         (nxt_sel),
        .value       (nxt_val)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            remain   <= '0;
            coin_sel <= 1'b0;
            coin_val <= COIN1_VAL;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req) begin
                        remain <= amount;
                        if (amount == '0) begin
                            state <= DONE;
                        end else begin
                            state    <= ISSUE;
                            coin_sel <= nxt_sel;
                            coin_val <= nxt_val;
                        end
                    end
                end
                ISSUE: begin
                    if (hopper_ack) begin
                        remain <= remain_nxt;
                        state  <= (remain_nxt == '0) ? DONE : SETTLE;
                    end
                end
                SETTLE: begin
                    state    <= ISSUE;
                    coin_sel <= nxt_sel;
                    coin_val <= nxt_val;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy     = (state != IDLE);
    assign coin_vld = (state == ISSUE);
    assign done     = (state == DONE);

`ifdef PAYOUT_TOTAL_EN
    localparam int SUM_W = TOTAL_W + 1;

    logic [SUM_W-1:0] sum;

    // One extra bit catches the carry so the total can clamp at all-ones.
    assign sum = {1'b0, total} + SUM_W'(coin_val);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            total <= '0;
        end else if (state == ISSUE && hopper_ack) begin
            total <= sum[TOTAL_W] ? '1 : sum[TOTAL_W-1:0];
        end
    end
`endif

endmodule

// File: tb/tb_vend_coin_payout.sv
// Self-checking bench for vend_coin_payout: a vector table for the basic
// payouts plus hand-written sequences for stalls and mid-payout reset.
module tb_vend_coin_payout;

`ifdef PAYOUT_TOTAL_EN
`define CHK_TOTAL(nm, e) chk(nm, 32'(total), 32'(e));
`else
`define CHK_TOTAL(nm, e)
`endif

    logic       clk;
    logic       rstn;
    logic       req;
    logic [3:0] amount;
    logic       coin2_empty;
    logic       hopper_ack;
    logic       busy;
    logic       coin_vld;
    logic       coin_sel;
    logic       done;
`ifdef PAYOUT_TOTAL_EN
    logic [2:0] total;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    vend_coin_payout #(
        .CREDIT_W (4)
`ifdef PAYOUT_TOTAL_EN
        ,
        .TOTAL_W  (3)
`endif
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .req         (req),
        .amount      (amount),
        .coin2_empty (coin2_empty),
        .hopper_ack  (hopper_ack),
        .busy        (busy),
        .coin_vld    (coin_vld),
        .coin_sel    (coin_sel),
        .done        (done)
`ifdef PAYOUT_TOTAL_EN
        ,
        .total       (total)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       req;
        logic [3:0] amt;
        logic       empty;
        logic       ack;
        logic       busy;
        logic       vld;
        logic       sel;
        logic       done;
        int         total;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit r, int a, bit e, bit k,
                                bit b, bit vl, bit s, bit d, int t);
        vec_t v;
        v.req   = r;
        v.amt   = 4'(a);
        v.empty = e;
        v.ack   = k;
        v.busy  = b;
        v.vld   = vl;
        v.sel   = s;
        v.done  = d;
        v.total = t;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string nm, input bit b, input bit vl,
                           input bit s, input bit d);
        chk({nm, " busy"}, 32'(busy), 32'(b));
        chk({nm, " coin_vld"}, 32'(coin_vld), 32'(vl));
        chk({nm, " coin_sel"}, 32'(coin_sel), 32'(s));
        chk({nm, " done"}, 32'(done), 32'(d));
    endtask

    initial begin
        // req, amt, empty, ack | busy, vld, sel, done, total
        // amount 0: straight to DONE, no coin
        vecs.push_back(mk(1, 0, 0, 0, 1, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        // amount 5, tube full, ack held: sel 1,1,0; req while busy ignored
        vecs.push_back(mk(1, 5, 0, 1, 1, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 0, 1, 0, 2));
        vecs.push_back(mk(0, 0, 0, 1, 1, 1, 1, 0, 2));
        vecs.push_back(mk(1, 7, 0, 1, 1, 0, 1, 0, 4));
        vecs.push_back(mk(0, 0, 0, 1, 1, 1, 0, 0, 4));
        vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0, 1, 5));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 5));
        // amount 4, tube empty: four 1-coins; total saturates at 7
        vecs.push_back(mk(1, 4, 1, 1, 1, 1, 0, 0, 5));
        vecs.push_back(mk(0, 0, 1, 1, 1, 0, 0, 0, 6));
        vecs.push_back(mk(1, 2, 1, 1, 1, 1, 0, 0, 6));
        vecs.push_back(mk(0, 0, 1, 1, 1, 0, 0, 0, 7));
        vecs.push_back(mk(0, 0, 1, 1, 1, 1, 0, 0, 7));
        vecs.push_back(mk(0, 0, 1, 1, 1, 0, 0, 0, 7));
        vecs.push_back(mk(0, 0, 1, 1, 1, 1, 0, 0, 7));
        vecs.push_back(mk(0, 0, 1, 1, 1, 0, 0, 1, 7));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 7));

        // reset held with req asserted
        rstn        = 1'b0;
        req         = 1'b1;
        amount      = 4'd3;
        coin2_empty = 1'b0;
        hopper_ack  = 1'b1;
        #1;
        chk_out("reset t0", 0, 0, 0, 0);
        `CHK_TOTAL("reset t0 total", 0)
        repeat (3) tick();
        chk_out("reset held", 0, 0, 0, 0);
        `CHK_TOTAL("reset held total", 0)
        rstn = 1'b1;

        foreach (vecs[i]) begin
            req         = vecs[i].req;
            amount      = vecs[i].amt;
            coin2_empty = vecs[i].empty;
            hopper_ack  = vecs[i].ack;
            tick();
            chk_out($sformatf("vec%0d", i), vecs[i].busy, vecs[i].vld,
                    vecs[i].sel, vecs[i].done);
            `CHK_TOTAL($sformatf("vec%0d total", i), vecs[i].total)
        end

        // amount 4, first coin stalled 10 cycles while the tube toggles
        req         = 1'b1;
        amount      = 4'd4;
        coin2_empty = 1'b0;
        hopper_ack  = 1'b0;
        tick();
        chk_out("stall issue", 1, 1, 1, 0);
        req = 1'b0;
        for (int k = 0; k < 10; k++) begin
            coin2_empty = (k % 2 == 0);
            tick();
            chk_out($sformatf("stall c%0d", k), 1, 1, 1, 0);
        end
        coin2_empty = 1'b0;
        hopper_ack  = 1'b1;
        tick();
        chk_out("stall settle", 1, 0, 1, 0);
        tick();
        chk_out("stall issue2", 1, 1, 1, 0);
        tick();
        chk_out("stall done", 1, 0, 1, 1);
        hopper_ack = 1'b0;
        tick();
        chk_out("stall idle", 0, 0, 1, 0);
        `CHK_TOTAL("stall total", 7)

        // amount 3, reset during the first SETTLE
        req         = 1'b1;
        amount      = 4'd3;
        hopper_ack  = 1'b1;
        tick();
        chk_out("rst issue", 1, 1, 1, 0);
        req = 1'b0;
        tick();
        chk_out("rst settle", 1, 0, 1, 0);
        rstn = 1'b0;
        #1;
        chk_out("rst async", 0, 0, 0, 0);
        `CHK_TOTAL("rst async total", 0)
        #1;
        rstn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_out($sformatf("rst after c%0d", k), 0, 0, 0, 0);
        end

        // fresh amount 3 after reset: latency c1..c5
        req    = 1'b1;
        amount = 4'd3;
        tick();
        chk_out("a3 c1", 1, 1, 1, 0);
        req = 1'b0;
        tick();
        chk_out("a3 c2", 1, 0, 1, 0);
        `CHK_TOTAL("a3 c2 total", 2)
        tick();
        chk_out("a3 c3", 1, 1, 0, 0);
        tick();
        chk_out("a3 c4", 1, 0, 0, 1);
        `CHK_TOTAL("a3 c4 total", 3)
        tick();
        chk_out("a3 c5", 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
